// File: rtl/vproc_pkg.sv
// Shared types and helpers for the vector result path: destination element width,
// per-beat packing flags and the narrowing/saturation helper.
package vproc_pkg;

    typedef enum logic [1:0] {
        VSEW_8       = 2'b00,
        VSEW_16      = 2'b01,
        VSEW_32      = 2'b10,
        VSEW_INVALID = 2'b11
    } cfg_vsew;

    typedef struct packed {
        logic       shift;     // accumulate beats into a word (0: flush every beat)
        logic       elemwise;  // only element 0 of the beat is packed
        logic       narrow;    // 2*SEW source elements narrowed to SEW
        logic       saturate;  // clamp instead of truncate when narrowing
        logic       sig;       // source elements are signed
        logic [2:0] mul_idx;   // register offset within the register group
    } pack_flags;

    // Largest number of bytes the fill counter has to track in one vreg word;
    // bounds VREG_W to 512 bits and sizes the counter.
    localparam int unsigned PACK_MAX_SHIFT = 64;

    typedef struct packed {
        logic [31:0] val;
        logic        sat;
    } narrow_res_t;

    // Narrow one 2*SEW element to SEW with clamping; val holds the result in its
    // low SEW bits, sat flags that clamping changed the value.
    function automatic narrow_res_t vproc_sat_narrow(input logic [63:0] elem,
                                                     input cfg_vsew     vsew,
                                                     input logic        sig);
        narrow_res_t       r;
        logic signed [64:0] v;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        r  = '0;
        v  = '0;
        hi = '0;
        lo = '0;
        case (vsew)
            VSEW_8: begin
                v  = sig ? {{49{elem[15]}}, elem[15:0]} : {49'b0, elem[15:0]};
                hi = sig ? 65'sd127 : 65'sd255;
                lo = sig ? -65'sd128 : 65'sd0;
            end
            VSEW_16: begin
                v  = sig ? {{33{elem[31]}}, elem[31:0]} : {33'b0, elem[31:0]};
                hi = sig ? 65'sd32767 : 65'sd65535;
                lo = sig ? -65'sd32768 : 65'sd0;
            end
            VSEW_32: begin
                v  = sig ? {elem[63], elem} : {1'b0, elem};
                hi = sig ? 65'sd2147483647 : 65'sd4294967295;
                lo = sig ? -65'sd2147483648 : 65'sd0;
            end
            default: ;
        endcase
        if (v > hi) begin
            r.val = hi[31:0];
            r.sat = 1'b1;
        end else if (v < lo) begin
            r.val = lo[31:0];
            r.sat = 1'b1;
        end else begin
            r.val = v[31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/vproc_result_pack_narrow_sat.sv
// Combinational narrowing of a RES_W result beat to RES_W/2 bits: truncate or
// saturate each 2*SEW element, merge byte enables pairwise, flag clamped bytes.
module vproc_result_pack_narrow_sat
    import vproc_pkg::*;
#(
    parameter int unsigned RES_W = 32
) (
    input  logic [RES_W-1:0]    res_i,
    input  logic [RES_W/8-1:0]  mask_i,
    input  cfg_vsew             vsew_i,
    input  logic                saturate_i,
    input  logic                sig_i,
    output logic [RES_W/2-1:0]  res_o,
    output logic [RES_W/16-1:0] be_o,
    output logic [RES_W/16-1:0] sat_o
);

    // Per-element narrowing; sat_o marks every output byte of a clamped element
    always_comb begin
        narrow_res_t nr;
        nr    = '0;
        res_o = '0;
        sat_o = '0;
        for (int k = 0; k < RES_W / 16; k++) begin
            be_o[k] = |mask_i[2*k +: 2];
        end
        case (vsew_i)
            VSEW_8: begin
                for (int e = 0; e < RES_W / 16; e++) begin
                    nr = vproc_sat_narrow({48'b0, res_i[16*e +: 16]}, VSEW_8, sig_i);
                    res_o[8*e +: 8] = saturate_i ? nr.val[7:0] : res_i[16*e +: 8];
                    sat_o[e]        = saturate_i & nr.sat;
                end
            end
            VSEW_16: begin
                for (int e = 0; e < RES_W / 32; e++) begin
                    nr = vproc_sat_narrow({32'b0, res_i[32*e +: 32]}, VSEW_16, sig_i);
                    res_o[16*e +: 16] = saturate_i ? nr.val[15:0] : res_i[32*e +: 16];
                    sat_o[2*e +: 2]   = {2{saturate_i & nr.sat}};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vproc_result_pack.sv
// Packs execution-unit result beats into vreg-wide words and issues byte-enabled
// vector register writes, with optional narrowing/saturation on the way in.
module vproc_result_pack
    import vproc_pkg::*;
#(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned RES_W  = 32
) (
    input  logic                clk_i,
    input  logic                async_rst_i,
    input  logic                res_valid_i,
    output logic                res_ready_o,
    input  logic [RES_W-1:0]    res_i,
    input  logic [RES_W/8-1:0]  res_mask_i,
    input  pack_flags           res_flags_i,
    input  cfg_vsew             res_vsew_i,
    input  logic [4:0]          res_vaddr_i,
    input  logic                res_last_i,
    output logic                vreg_wr_en_o,
    input  logic                vreg_wr_ready_i,
    output logic [4:0]          vreg_wr_addr_o,
    output logic [VREG_W-1:0]   vreg_wr_o,
    output logic [VREG_W/8-1:0] vreg_wr_be_o,
    output logic                vxsat_o
);

    localparam int unsigned VB    = VREG_W / 8;
    localparam int unsigned RB    = RES_W / 8;
    localparam int unsigned CNT_W = $clog2(PACK_MAX_SHIFT + 1);
    localparam logic [CNT_W-1:0] VB_C = CNT_W'(VB);

    // Staging shift register, its byte enables and fill count (in bytes)
    logic [VREG_W-1:0] stage_q, stage_d;
    logic [VB-1:0]     sbe_q, sbe_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wnarrow_q, wnarrow_d;
    // Write register
    logic [VREG_W-1:0] out_q, out_d;
    logic [VB-1:0]     obe_q, obe_d;
    logic [4:0]        oaddr_q, oaddr_d;
    logic              oen_q, oen_d;
    logic              vxsat_q, vxsat_d;

    logic [RES_W/2-1:0]  nar_res;
    logic [RES_W/16-1:0] nar_be;
    logic [RES_W/16-1:0] nar_sat;

    logic [RES_W-1:0] beat_data;
    logic [RB-1:0]    beat_be;
    logic [RB-1:0]    beat_sat;
    logic [CNT_W-1:0] beat_nb;
    logic [CNT_W-1:0] sew_bytes;
    logic             accept;

    vproc_result_pack_narrow_sat #(
        .RES_W (RES_W)
    ) u_narrow_sat (
        .res_i      (res_i),
        .mask_i     (res_mask_i),
        .vsew_i     (res_vsew_i),
        .saturate_i (res_flags_i.saturate),
        .sig_i      (res_flags_i.sig),
        .res_o      (nar_res),
        .be_o       (nar_be),
        .sat_o      (nar_sat)
    );

    // A new beat is only blocked by a write that is stalled this cycle
    assign res_ready_o = !(oen_q && !vreg_wr_ready_i);
    assign accept      = res_valid_i && res_ready_o;

    // Destination element size in bytes
    always_comb begin
        case (res_vsew_i)
            VSEW_8:  sew_bytes = CNT_W'(1);
            VSEW_16: sew_bytes = CNT_W'(2);
            default: sew_bytes = CNT_W'(4);
        endcase
    end

    // Select the bytes this beat contributes, right-aligned, and its width
    always_comb begin
        beat_data = res_i;
        beat_be   = res_mask_i;
        beat_sat  = '0;
        beat_nb   = CNT_W'(RB);
        if (res_flags_i.narrow) begin
            beat_data = RES_W'(nar_res);
            beat_be   = RB'(nar_be);
            beat_sat  = RB'(nar_sat);
            beat_nb   = CNT_W'(RB / 2);
        end
        if (res_flags_i.elemwise) begin
            beat_nb = sew_bytes;
            for (int b = 0; b < RB; b++) begin
                if (b >= int'(sew_bytes)) begin
                    beat_data[8*b +: 8] = '0;
                    beat_be[b]          = 1'b0;
                    beat_sat[b]         = 1'b0;
                end
            end
        end
        beat_sat = beat_sat & beat_be;
    end

    // Next state: shift beat in at the MSB side, complete/flush into the write register
    always_comb begin
        logic [VREG_W-1:0] stage_sh;
        logic [VB-1:0]     be_sh;
        logic [CNT_W-1:0]  cnt_sum;
        logic [CNT_W-1:0]  cnt_fill;
        int unsigned       pad;
        stage_sh  = (stage_q >> (8 * int'(beat_nb)))
                  | (VREG_W'(beat_data) << (VREG_W - 8 * int'(beat_nb)));
        be_sh     = (sbe_q >> int'(beat_nb)) | (VB'(beat_be) << (VB - int'(beat_nb)));
        cnt_sum   = cnt_q + beat_nb;
        cnt_fill  = (cnt_sum > VB_C) ? VB_C : cnt_sum;
        pad       = VB - int'(cnt_fill);
        stage_d   = stage_q;
        sbe_d     = sbe_q;
        cnt_d     = cnt_q;
        wnarrow_d = wnarrow_q;
        out_d     = out_q;
        obe_d     = obe_q;
        oaddr_d   = oaddr_q;
        oen_d     = oen_q && !vreg_wr_ready_i;
        vxsat_d   = accept && (|beat_sat);
        if (accept) begin
            if (cnt_q == '0) begin
                wnarrow_d = res_flags_i.narrow;
            end
            if (!res_flags_i.shift || res_last_i || (cnt_sum >= VB_C)) begin
                if (res_flags_i.shift) begin
                    // a short word is right-aligned so its first byte lands at byte 0
                    out_d = stage_sh >> (8 * pad);
                    obe_d = be_sh >> pad;
                end else begin
                    out_d = VREG_W'(beat_data);
                    obe_d = VB'(beat_be);
                end
                oaddr_d = res_vaddr_i | {2'b00, res_flags_i.mul_idx};
                oen_d   = 1'b1;
                stage_d = '0;
                sbe_d   = '0;
                cnt_d   = '0;
            end else begin
                stage_d = stage_sh;
                sbe_d   = be_sh;
                cnt_d   = cnt_sum;
            end
        end
    end

    // State registers; reset drops any partial word and pending write
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            stage_q   <= '0;
            sbe_q     <= '0;
            cnt_q     <= '0;
            wnarrow_q <= 1'b0;
            out_q     <= '0;
            obe_q     <= '0;
            oaddr_q   <= '0;
            oen_q     <= 1'b0;
            vxsat_q   <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            sbe_q     <= sbe_d;
            cnt_q     <= cnt_d;
            wnarrow_q <= wnarrow_d;
            out_q     <= out_d;
            obe_q     <= obe_d;
            oaddr_q   <= oaddr_d;
            oen_q     <= oen_d;
            vxsat_q   <= vxsat_d;
        end
    end

    assign vreg_wr_en_o   = oen_q;
    assign vreg_wr_addr_o = oaddr_q;
    assign vreg_wr_o      = out_q;
    assign vreg_wr_be_o   = obe_q;
    assign vxsat_o        = vxsat_q;

    a_vsew_valid: assert property (@(posedge clk_i) disable iff (async_rst_i)
        accept |-> res_vsew_i != VSEW_INVALID);
    a_narrow_sew: assert property (@(posedge clk_i) disable iff (async_rst_i)
        (accept && res_flags_i.narrow) |-> res_vsew_i inside {VSEW_8, VSEW_16});
    a_no_mix: assert property (@(posedge clk_i) disable iff (async_rst_i)
        (accept && res_flags_i.shift && cnt_q != '0) |-> res_flags_i.narrow == wnarrow_q);

endmodule

// File: tb/tb_vproc_result_pack.sv
// Directed bench for vproc_result_pack with hand-computed write words.
module tb_vproc_result_pack;
    import vproc_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res;
    logic [3:0]   res_mask;
    pack_flags    flags;
    cfg_vsew      vsew;
    logic [4:0]   vaddr;
    logic         last;
    logic         wr_en;
    logic         wr_ready;
    logic [4:0]   wr_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_be;
    logic         vxsat;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  be;
        logic [4:0]   a;
    } wr_t;
    wr_t wq[$];

    int n_chk  = 0;
    int n_fail = 0;
    int vx_cnt = 0;
    int vx0;

    vproc_result_pack #(.VREG_W(128), .RES_W(32)) dut (
        .clk_i           (clk),
        .async_rst_i     (rst),
        .res_valid_i     (res_valid),
        .res_ready_o     (res_ready),
        .res_i           (res),
        .res_mask_i      (res_mask),
        .res_flags_i     (flags),
        .res_vsew_i      (vsew),
        .res_vaddr_i     (vaddr),
        .res_last_i      (last),
        .vreg_wr_en_o    (wr_en),
        .vreg_wr_ready_i (wr_ready),
        .vreg_wr_addr_o  (wr_addr),
        .vreg_wr_o       (wr_data),
        .vreg_wr_be_o    (wr_be),
        .vxsat_o         (vxsat)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && wr_en && wr_ready) wq.push_back('{wr_data, wr_be, wr_addr});
        if (!rst && vxsat) vx_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pack_flags mkf(input logic sh, input logic el, input logic nr,
                                      input logic st, input logic sg, input logic [2:0] mi);
        pack_flags f;
        f.shift = sh; f.elemwise = el; f.narrow = nr;
        f.saturate = st; f.sig = sg; f.mul_idx = mi;
        return f;
    endfunction

    task automatic send(input logic [31:0] d, input logic [3:0] m, input pack_flags f,
                        input cfg_vsew sew, input logic [4:0] a, input logic l);
        int waited;
        @(negedge clk);
        res_valid = 1'b1; res = d; res_mask = m; flags = f; vsew = sew; vaddr = a; last = l;
        waited = 0;
        while (!res_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) chk("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1 res_valid = 1'b0; last = 1'b0;
    endtask

    task automatic expect_wr(input string tag, input logic [127:0] d, input logic [15:0] be,
                             input logic [4:0] a);
        wr_t w;
        for (int i = 0; i < 20 && wq.size() == 0; i++) @(posedge clk);
        if (wq.size() == 0) begin
            chk({tag, "_timeout"}, 1'b0, 1'b1);
        end else begin
            w = wq.pop_front();
            chk({tag, "_data"}, w.d, d);
            chk({tag, "_be"}, w.be, be);
            chk({tag, "_addr"}, w.a, a);
        end
    endtask

    initial begin
        rst = 1'b1; res_valid = 1'b0; res = '0; res_mask = '0; flags = '0;
        vsew = VSEW_32; vaddr = '0; last = 1'b0; wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_en", wr_en, 1'b0);
        chk("rst_ready", res_ready, 1'b1);
        chk("rst_vxsat", vxsat, 1'b0);
        chk("rst_data", wr_data, 128'h0);
        chk("rst_be_addr", {wr_be, wr_addr}, 21'h0);
        rst = 1'b0;

        // 1: four full-width beats
        send(32'h11111111, 4'hF, mkf(1,0,0,0,0,3'd0), VSEW_32, 5'd8, 0);
        send(32'h22222222, 4'hF, mkf(1,0,0,0,0,3'd0), VSEW_32, 5'd8, 0);
        send(32'h33333333, 4'hF, mkf(1,0,0,0,0,3'd0), VSEW_32, 5'd8, 0);
        chk("t1_no_early_wr", wr_en, 1'b0);
        send(32'h44444444, 4'hF, mkf(1,0,0,0,0,3'd0), VSEW_32, 5'd8, 0);
        chk("t1_latency", wr_en, 1'b1);
        expect_wr("t1", 128'h44444444333333332222222211111111, 16'hFFFF, 5'd8);

        // 2: signed saturating narrow to 16 bits
        vx0 = vx_cnt;
        send(32'h7FFF8000, 4'hF, mkf(1,0,1,1,1,3'd1), VSEW_16, 5'd4, 0);
        chk("t2_vxsat_pulse", vxsat, 1'b1);
        send(32'hFFFF8000, 4'hF, mkf(1,0,1,1,1,3'd1), VSEW_16, 5'd4, 0);
        chk("t2_vxsat_quiet", vxsat, 1'b0);
        send(32'h80000000, 4'hF, mkf(1,0,1,1,1,3'd1), VSEW_16, 5'd4, 0);
        send(32'h00001234, 4'hF, mkf(1,0,1,1,1,3'd1), VSEW_16, 5'd4, 0);
        send(32'h00000001, 4'hF, mkf(1,0,1,1,1,3'd1), VSEW_16, 5'd4, 0);
        send(32'hFFFFFFFE, 4'hF, mkf(1,0,1,1,1,3'd1), VSEW_16, 5'd4, 0);
        send(32'h00010000, 4'hF, mkf(1,0,1,1,1,3'd1), VSEW_16, 5'd4, 0);
        send(32'hFFFF7FFF, 4'hF, mkf(1,0,1,1,1,3'd1), VSEW_16, 5'd4, 0);
        expect_wr("t2", 128'h80007FFFFFFE0001123480008000_7FFF, 16'hFFFF, 5'd5);
        @(negedge clk);
        chk("t2_vxsat_count", vx_cnt - vx0, 4);

        // 3: unsigned saturate to bytes, then a signed in-range value, flushed by last
        vx0 = vx_cnt;
        send(32'h010000FF, 4'hF, mkf(1,0,1,1,0,3'd2), VSEW_8, 5'd5, 0);
        send(32'h0000FF80, 4'hF, mkf(1,0,1,1,1,3'd2), VSEW_8, 5'd5, 1);
        expect_wr("t3", 128'h0080FFFF, 16'h000F, 5'd7);
        @(negedge clk);
        chk("t3_vxsat_count", vx_cnt - vx0, 1);

        // 4: element-wise bytes 0..15 with alternating masks
        for (int i = 0; i < 16; i++)
            send(32'(i), (i % 2 == 0) ? 4'hF : 4'h0, mkf(1,1,0,0,0,3'd0), VSEW_8, 5'd12, 0);
        expect_wr("t4", 128'h0F0E0D0C0B0A09080706050403020100, 16'h5555, 5'd12);

        // 5: early last, then a clean full word
        send(32'hAAAA0001, 4'hF, mkf(1,0,0,0,0,3'd0), VSEW_32, 5'd16, 0);
        send(32'hAAAA0002, 4'hF, mkf(1,0,0,0,0,3'd0), VSEW_32, 5'd16, 1);
        expect_wr("t5a", 128'h0000000000000000AAAA0002AAAA0001, 16'h00FF, 5'd16);
        for (int i = 5; i < 9; i++)
            send(32'(i), 4'hF, mkf(1,0,0,0,0,3'd0), VSEW_32, 5'd16, 0);
        expect_wr("t5b", 128'h00000008000000070000000600000005, 16'hFFFF, 5'd16);

        // non-accumulating beat flushes at offset 0
        send(32'hDEADBEEF, 4'h3, mkf(0,0,0,0,0,3'd1), VSEW_32, 5'd20, 0);
        expect_wr("t_noshift", 128'hDEADBEEF, 16'h0003, 5'd21);

        // 6: write back-pressure holds data/addr and blocks new beats
        @(posedge clk); #1 wr_ready = 1'b0;
        for (int i = 1; i < 5; i++)
            send({4{8'(i)}}, 4'hF, mkf(1,0,0,0,0,3'd3), VSEW_32, 5'd0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_ready_low", res_ready, 1'b0);
            chk("t6_en_held", wr_en, 1'b1);
            chk("t6_data_held", wr_data, 128'h04040404030303030202020201010101);
            chk("t6_addr_held", wr_addr, 5'd3);
        end
        @(posedge clk); #1 wr_ready = 1'b1;
        expect_wr("t6", 128'h04040404030303030202020201010101, 16'hFFFF, 5'd3);

        // reset mid-word discards the partial word
        send(32'hEEEE0001, 4'hF, mkf(1,0,0,0,0,3'd0), VSEW_32, 5'd9, 0);
        send(32'hEEEE0002, 4'hF, mkf(1,0,0,0,0,3'd0), VSEW_32, 5'd9, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_ready", res_ready, 1'b1);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        chk("t6_rst_no_wr", wq.size(), 0);
        chk("t6_rst_en", wr_en, 1'b0);
        for (int i = 9; i < 13; i++)
            send(32'(i), 4'hF, mkf(1,0,0,0,0,3'd0), VSEW_32, 5'd9, 0);
        expect_wr("t6_after_rst", 128'h0000000C0000000B0000000A00000009, 16'hFFFF, 5'd9);

        repeat (3) @(posedge clk);
        chk("final_queue_empty", wq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
